// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg
//   Shared definitions for the SRAM / memory-mapped I/O controller.
//   - state_t          : controller FSM state encoding
//   - IO_SW_ADDR_DEF   : default address whose reads return the switches
//   - IO_HEX_ADDR_DEF  : default address whose writes load the hex display
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [15:0] IO_SW_ADDR_DEF  = 16'hFFFF;
    localparam logic [15:0] IO_HEX_ADDR_DEF = 16'hFFFF;

endpackage

// File: rtl/sram_mem_ctrl_mmio_decode.sv
// mmio_decode
//   Memory-mapped I/O address decode plus the hex display register.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     accept   : a request is being accepted this cycle
//     wr       : 1 = write, 0 = read (of the request being presented)
//     addr     : CPU address of the request being presented
//     wdata    : write data of the request being presented
//     io_hit   : combinational; request targets an I/O location, not SRAM
//     hex_out  : hex display register
module mmio_decode #(
    parameter int              AW          = 16,
    parameter int              DW          = 16,
    parameter logic [AW-1:0]   IO_SW_ADDR  = '1,
    parameter logic [AW-1:0]   IO_HEX_ADDR = '1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          accept,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          io_hit,
    output logic [DW-1:0] hex_out
);

    // The switch and hex locations may share an address: direction picks
    // which one a request actually hits.
    logic sw_hit;
    logic hex_hit;

    assign sw_hit  = !wr && (addr == IO_SW_ADDR);
    assign hex_hit =  wr && (addr == IO_HEX_ADDR);
    assign io_hit  = sw_hit || hex_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hex_out <= '0;
        end else if (accept && hex_hit) begin
            hex_out <= wdata;
        end
    end

endmodule

// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl
//   Request/ready controller between the CPU datapath and an external
//   asynchronous SRAM, with memory-mapped switches and hex display.
//
//   Handshake: req is sampled only in IDLE; the request fields (wr, addr,
//   wdata, byte_en) are captured on the accepting edge and may change
//   afterwards. ready is a one-cycle completion pulse; rdata is valid while
//   ready = 1 and holds until the next read completes. busy is high in every
//   state but IDLE, and req seen while busy is dropped, not queued.
//
//   Ports:
//     clk, rst          : clock, asynchronous active-high reset
//     req, wr, addr,
//     wdata, byte_en    : CPU request
//     rdata, ready, busy: CPU completion / status
//     mem_ce/oe/we      : SRAM strobes, active low
//     mem_be_n          : SRAM byte lanes, active low
//     mem_addr          : zero-extended captured address
//     mem_data_out/oe   : data and drive enable toward the external tristate
//     mem_data_in       : data from the external tristate
//     switches, hex_out : board I/O
//     dbg_state         : current FSM state
module sram_mem_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int            DW          = 16,
    parameter int            AW          = 16,
    parameter int            SRAM_AW     = 20,
    parameter int            WAIT        = 1,
    parameter logic [AW-1:0] IO_SW_ADDR  = AW'(IO_SW_ADDR_DEF),
    parameter logic [AW-1:0] IO_HEX_ADDR = AW'(IO_HEX_ADDR_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic               wr,
    input  logic [AW-1:0]      addr,
    input  logic [DW-1:0]      wdata,
    input  logic [DW/8-1:0]    byte_en,
    output logic [DW-1:0]      rdata,
    output logic               ready,
    output logic               busy,
    output logic               mem_ce,
    output logic               mem_oe,
    output logic               mem_we,
    output logic [DW/8-1:0]    mem_be_n,
    output logic [SRAM_AW-1:0] mem_addr,
    output logic [DW-1:0]      mem_data_out,
    output logic               mem_data_oe,
    input  logic [DW-1:0]      mem_data_in,
    input  logic [DW-1:0]      switches,
    output logic [DW-1:0]      hex_out,
    output state_t             dbg_state
);

    localparam int CW = (WAIT > 1) ? $clog2(WAIT) : 1;

    state_t        state_q;
    state_t        next_state;
    logic [CW-1:0] cnt_q;
    logic          wr_q;
    logic          accept;
    logic          io_hit;
    logic          last_access;
    logic          wr_eff;
    logic          sram_next;

    assign accept      = (state_q == ST_IDLE) && req;
    assign last_access = (state_q == ST_ACCESS) && (cnt_q == '0);
    // On the accepting edge wr_q is not yet loaded, so look at the live input.
    assign wr_eff      = (state_q == ST_IDLE) ? wr : wr_q;
    assign sram_next   = (next_state == ST_SETUP) || (next_state == ST_ACCESS);
    assign dbg_state   = state_q;

    mmio_decode #(
        .AW          (AW),
        .DW          (DW),
        .IO_SW_ADDR  (IO_SW_ADDR),
        .IO_HEX_ADDR (IO_HEX_ADDR)
    ) u_mmio (
        .clk     (clk),
        .rst     (rst),
        .accept  (accept),
        .wr      (wr),
        .addr    (addr),
        .wdata   (wdata),
        .io_hit  (io_hit),
        .hex_out (hex_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    always_comb begin
        next_state = state_q;
        case (state_q)
            ST_IDLE:   if (req) next_state = io_hit ? ST_DONE : ST_SETUP;
            ST_SETUP:  next_state = ST_ACCESS;
            ST_ACCESS: if (cnt_q == '0) next_state = ST_DONE;
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Every output is a flop whose D input is decoded from next_state, so the
    // strobes change exactly as the state does, with no glitch path from req.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            busy         <= 1'b0;
            ready        <= 1'b0;
            mem_ce       <= 1'b1;
            mem_oe       <= 1'b1;
            mem_we       <= 1'b1;
            mem_be_n     <= '1;
            mem_data_oe  <= 1'b0;
            mem_addr     <= '0;
            mem_data_out <= '0;
            rdata        <= '0;
        end else begin
            busy   <= (next_state != ST_IDLE);
            ready  <= (next_state == ST_DONE);
            mem_ce <= !sram_next;
            mem_oe <= !(sram_next && !wr_eff);
            mem_we <= !((next_state == ST_ACCESS) && wr_eff);
            // Drive continues through DONE (WE already high) for data hold;
            // an I/O write reaches DONE straight from IDLE and never drives.
            mem_data_oe <= wr_eff && ((next_state == ST_ACCESS) ||
                           ((next_state == ST_DONE) && (state_q == ST_ACCESS)));

            if (accept) begin
                wr_q     <= wr;
                mem_be_n <= io_hit ? '1 : ~byte_en;
                if (!io_hit) begin
                    mem_addr     <= SRAM_AW'(addr);
                    mem_data_out <= wdata;
                end
                if (io_hit && !wr) begin
                    rdata <= switches;
                end
            end else if (!sram_next) begin
                mem_be_n <= '1;
            end

            if (state_q == ST_SETUP) begin
                cnt_q <= CW'(WAIT - 1);
            end else if ((state_q == ST_ACCESS) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CW'(1);
            end

            if (last_access && !wr_q) begin
                rdata <= mem_data_in;
            end
        end
    end

endmodule
